// File: rtl/tff_ctrl_pkg.sv
// Shared types and helpers for the toggle-flip-flop counter controller.
package tff_ctrl_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Toggle mask that moves count one step; callers truncate to their width.
    function automatic logic [MAX_W-1:0] next_toggle(input logic [MAX_W-1:0] count,
                                                     input logic up);
        return count ^ (up ? count + 1'b1 : count - 1'b1);
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle cells, falling-edge clocked, reset to zero.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] T_VEC,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        always_ff @(negedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                q_q[i] <= 1'b0;
            end else if (T_VEC[i]) begin
                q_q[i] <= ~q_q[i];
            end
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/stop up/down counter built from a T-FF bank; the controller only
// issues toggle enables, the count itself lives in the bank.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             UP,
    input  logic [WIDTH-1:0] MOD,
    input  logic             PAUSE,
    output logic [WIDTH-1:0] COUNT,
    output logic [WIDTH-1:0] T_VEC,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       STATE_DBG
);

    // Handshake: START is a level sampled on the falling edge only while IDLE;
    // UP and MOD are captured on that same edge and ignored otherwise.

    state_t           state_q, state_d;
    logic             up_q;
    logic [WIDTH-1:0] mod_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] init;

    assign term = up_q ? mod_q : '0;
    assign init = up_q ? '0 : mod_q;

    always_comb begin
        state_d = state_q;
        t_vec   = '0;
        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                t_vec   = COUNT ^ init;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Terminal check wins over PAUSE so a paused run still finishes.
                if (COUNT == term) begin
                    state_d = ST_DONE;
                end else if (!PAUSE) begin
                    t_vec = WIDTH'(next_toggle(MAX_W'(COUNT), up_q));
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b0;
            mod_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && START) begin
                up_q  <= UP;
                mod_q <= MOD;
            end
        end
    end

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .CLK   (CLK),
        .RST_N (RST_N),
        .T_VEC (t_vec),
        .Q     (COUNT)
    );

    assign T_VEC     = t_vec;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl with a per-edge expected-value queue.
module tb_tff_count_ctrl;

  localparam int W = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic         clk_r;
  logic         rst_n_r;
  logic         start_r;
  logic         up_r;
  logic [W-1:0] mod_r;
  logic         pause_r;
  logic [W-1:0] count_w;
  logic [W-1:0] t_vec_w;
  logic         busy_w;
  logic         done_w;
  logic [1:0]   state_w;

  // Packed sample: {state, busy, done, count, t_vec}
  logic [2*W+3:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .CLK       (clk_r),
    .RST_N     (rst_n_r),
    .START     (start_r),
    .UP        (up_r),
    .MOD       (mod_r),
    .PAUSE     (pause_r),
    .COUNT     (count_w),
    .T_VEC     (t_vec_w),
    .BUSY      (busy_w),
    .DONE      (done_w),
    .STATE_DBG (state_w)
  );

  // clock / reset
  initial clk_r = 1'b1;
  always #5 clk_r = ~clk_r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W+3:0] pack_obs();
    return {state_w, busy_w, done_w, count_w, t_vec_w};
  endfunction

  task automatic chk(input string tag, input logic [2*W+3:0] obs, input logic [2*W+3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [W-1:0] cnt, input logic [W-1:0] tv);
    logic busy_e;
    logic done_e;
    busy_e = (st == S_LOAD) || (st == S_RUN);
    done_e = (st == S_DONE);
    exp_q.push_back({st, busy_e, done_e, cnt, tv});
  endtask

  // Expected samples, one per falling edge starting with the START edge.
  task automatic push_run(input logic up, input logic [W-1:0] m, input logic [W-1:0] prev,
                          input logic [W-1:0] pause_c, input int pause_n);
    logic [W-1:0] init_v;
    logic [W-1:0] term_v;
    logic [W-1:0] c;
    logic [W-1:0] nxt;
    init_v = up ? '0 : m;
    term_v = up ? m : '0;
    push_exp(S_LOAD, prev, prev ^ init_v);
    c = init_v;
    while (c != term_v) begin
      if (c == pause_c) begin
        for (int i = 0; i < pause_n; i++) push_exp(S_RUN, c, '0);
      end
      nxt = up ? c + 1'b1 : c - 1'b1;
      push_exp(S_RUN, c, c ^ nxt);
      c = nxt;
    end
    push_exp(S_RUN, term_v, '0);
    push_exp(S_DONE, term_v, '0);
    push_exp(S_IDLE, term_v, '0);
  endtask

  // driver: one falling edge per step; inputs for cycle k are set right after edge k
  task automatic run_steps(input string tag, input int n, input int pa, input int pb,
                           input int slo, input int shi);
    logic [2*W+3:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_r);
      #1;
      pause_r = (k == pa) || (k == pb);
      start_r = (k >= slo) && (k < shi);
      if (!start_r) begin
        up_r  = 1'($urandom_range(0, 1));
        mod_r = W'($urandom_range(0, 15));
      end
      @(posedge clk_r);
      #1;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL %s: observed empty queue expected sample at step %0d", tag, k);
      end else begin
        e = exp_q.pop_front();
        chk(tag, pack_obs(), e);
      end
    end
  endtask

  task automatic begin_run(input logic up, input logic [W-1:0] m);
    start_r = 1'b1;
    up_r    = up;
    mod_r   = m;
  endtask

  initial begin
    rst_n_r = 1'b0;
    start_r = 1'b0;
    up_r    = 1'b0;
    mod_r   = '0;
    pause_r = 1'b0;
    #12;
    chk("reset", pack_obs(), {S_IDLE, 1'b0, 1'b0, 4'h0, 4'h0});
    rst_n_r = 1'b1;

    // up run 0..5
    begin_run(1'b1, 4'd5);
    push_run(1'b1, 4'd5, 4'd0, 4'hF, 0);
    run_steps("up5", 9, -1, -1, -1, -1);

    // up run to 9 leaves COUNT=9 for the down run
    begin_run(1'b1, 4'd9);
    push_run(1'b1, 4'd9, 4'd5, 4'hF, 0);
    run_steps("up9", 13, -1, -1, -1, -1);

    // down run from 3, LOAD toggles 1010
    begin_run(1'b0, 4'd3);
    push_run(1'b0, 4'd3, 4'd9, 4'hF, 0);
    run_steps("down3", 7, -1, -1, -1, -1);

    // zero terminal finishes immediately with no toggles in RUN
    begin_run(1'b1, 4'd0);
    push_run(1'b1, 4'd0, 4'd0, 4'hF, 0);
    run_steps("mod0", 4, -1, -1, -1, -1);

    // full-range run, paused two cycles at COUNT=7
    begin_run(1'b1, 4'd15);
    push_run(1'b1, 4'd15, 4'd0, 4'd7, 2);
    run_steps("pause15", 21, 8, 9, -1, -1);

    // START held through DONE: back-to-back runs, one IDLE cycle between
    begin_run(1'b1, 4'd2);
    push_run(1'b1, 4'd2, 4'd15, 4'hF, 0);
    push_run(1'b1, 4'd2, 4'd2, 4'hF, 0);
    run_steps("b2b", 12, -1, -1, 0, 6);

    // START during RUN ignored, then async reset at COUNT=6
    begin_run(1'b1, 4'd10);
    push_run(1'b1, 4'd10, 4'd2, 4'hF, 0);
    run_steps("ignstart", 8, -1, -1, 3, 5);
    exp_q.delete();
    #2;
    rst_n_r = 1'b0;
    #1;
    chk("async_rst", pack_obs(), {S_IDLE, 1'b0, 1'b0, 4'h0, 4'h0});
    @(posedge clk_r);
    #1;
    rst_n_r = 1'b1;
    @(negedge clk_r);
    @(posedge clk_r);
    #1;
    chk("post_rst", pack_obs(), {S_IDLE, 1'b0, 1'b0, 4'h0, 4'h0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of WIDTH toggle flip-flops, making the bank behave as a start/stop, programmable-terminal up/down counter. All count state lives in the T-FF bank. The controller only issues per-bit toggle enables (T_VEC), computed each cycle as the XOR of the present and the wanted next count. It sits between a host that issues START/PAUSE and the toggle-cell storage.

## Interface
- WIDTH, 4, count width and number of T-FF cells (≥1)
- CLK  input  1  clock; all state changes on the falling edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  begin a run; sampled only in IDLE
- UP  input  1  direction, captured at START: 1 = count 0→MOD, 0 = count MOD→0
- MOD  input  WIDTH  terminal value, captured at START
- PAUSE  input  1  hold the count during RUN (T_VEC forced to 0)
- COUNT  output  WIDTH  Q outputs of the T-FF bank
- T_VEC  output  WIDTH  toggle enables presented to the bank (combinational, for observation)
- BUSY  output  1  high in LOAD and RUN
- DONE  output  1  one-cycle pulse in DONE state

## Operation
- States:
  - IDLE: T_VEC=0. START=1 captures UP→up_r and MOD→mod_r, then goes to LOAD.
  - LOAD: T_VEC = COUNT ^ init, where init = 0 if up_r, mod_r otherwise. Always goes to RUN.
  - RUN:
    - If COUNT == term (mod_r if up_r, 0 otherwise): T_VEC=0, go to DONE. This check has priority over PAUSE.
    - Else if PAUSE: T_VEC=0, stay in RUN.
    - Else: T_VEC = COUNT ^ (COUNT+1) when up_r, or COUNT ^ (COUNT−1) when down. Stay in RUN.
  - DONE: T_VEC=0, DONE=1. Always goes to IDLE.
- Each bank cell: on the falling edge, Q toggles if its T_VEC bit is 1.
- Arithmetic:
  - ±1 is computed in WIDTH bits.
  - The terminal check prevents any wrap, because the count never passes mod_r going up or 0 going down.
- START outside IDLE is ignored. UP and MOD are don't-care outside IDLE.
- The count holds its final value after DONE until the next LOAD.
- MOD=0, either direction: LOAD yields COUNT=0, then RUN immediately goes to DONE with no toggles.
- Reset, including mid-run: asynchronously state=IDLE, COUNT=0, up_r=0, mod_r=0. Outputs go to BUSY=0, DONE=0, T_VEC=0.

## Timing
- Edge 0: START sampled in IDLE; state becomes LOAD, BUSY=1.
- Edge 1: COUNT=init, state becomes RUN.
- Each unpaused RUN edge: COUNT changes by exactly 1.
- Up run with MOD=M and no pause:
  - COUNT=M after edge M+1.
  - DONE is high between edges M+2 and M+3.
  - IDLE at edge M+3.
- A down run has the same latency, with COUNT reaching 0 at edge M+1.
- Each paused cycle adds exactly one edge to every latency.
- START held high through DONE: a new run begins at the first edge in IDLE, so runs are back-to-back with one IDLE cycle between them.
- BUSY and DONE are never high together.

## Structure
- Package tff_ctrl_pkg holds:
  - the state enum IDLE/LOAD/RUN/DONE (2-bit encoding 0..3);
  - a function next_toggle(count, up) returning count ^ (count±1).
- Sub-module tff_bank:
  - WIDTH toggle cells;
  - falling-edge, async active-low reset to 0;
  - ports CLK, RST_N, T_VEC, Q.
- The controller FSM and the capture registers stay in tff_count_ctrl, which instantiates tff_bank.

## Test plan
- Reset, WIDTH=4, MOD=5, UP=1, START pulse:
  - COUNT steps 0,1,2,3,4,5 on successive edges;
  - DONE pulses once, 7 edges after START;
  - final COUNT=5, BUSY low afterwards.
- Down run, MOD=3, UP=0, COUNT=9 left from a prior run:
  - LOAD sets COUNT=3 (T_VEC=1010 in LOAD);
  - COUNT then goes 2,1,0 and DONE pulses.
- MOD=0, UP=1: COUNT=0 after LOAD, DONE one edge later, T_VEC=0 throughout RUN.
- MOD=15, UP=1 with PAUSE high for 2 RUN cycles at COUNT=7:
  - COUNT holds 7 for 2 cycles;
  - DONE is delayed by 2 cycles;
  - COUNT never exceeds 15 (no wrap).
- START re-asserted during RUN (ignored), then RST_N driven low mid-run at COUNT=6:
  - COUNT, BUSY, DONE and T_VEC go to 0 immediately, with no clock edge;
  - state IDLE after RST_N rises.
